// File: rtl/x1_setpoint_ramp_ctrl_if.sv
// Avalon-MM slave bus bundle for the x1 setpoint ramp controller.
interface x1_setpoint_ramp_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/x1_setpoint_ramp_ctrl.sv
// Ramps the 18-bit x1 setpoint toward a software target, one bounded step per tick.
//   state   | meaning
//   ST_IDLE | setpoint static; CURRENT writable; START evaluated
//   ST_RAMP | tick counter running; setpoint moves toward live target
module x1_setpoint_ramp_ctrl #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter logic [17:0] INIT_VALUE = 18'd0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    x1_setpoint_ramp_ctrl_if.slave        avs,
    output logic [17:0]                   setpoint,
    output logic                          busy,
    output logic                          done_pulse
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RAMP
    } state_t;

    state_t      r_state;
    logic [17:0] r_setpoint;
    logic [17:0] r_target;
    logic [17:0] r_step;
    logic [15:0] r_tick_cnt;
    logic        r_busy;
    logic        r_done_pulse;
    logic        r_done;
    logic        r_aborted;

    logic        w_wr;
    logic        w_wr_cur;
    logic        w_wr_tgt;
    logic        w_wr_step;
    logic        w_wr_ctrl;
    logic        w_start;
    logic        w_abort;
    logic        w_clr;
    logic        w_tick;
    logic        w_up;
    logic [17:0] w_step_eff;
    logic [17:0] w_dist;
    logic [17:0] w_inc;
    logic [17:0] w_next_sp;
    logic        w_unused_wdata;

    assign w_wr      = avs.chipselect && !avs.write_n;
    assign w_wr_cur  = w_wr && (avs.address == 2'd0);
    assign w_wr_tgt  = w_wr && (avs.address == 2'd1);
    assign w_wr_step = w_wr && (avs.address == 2'd2);
    assign w_wr_ctrl = w_wr && (avs.address == 2'd3);
    assign w_start   = w_wr_ctrl && avs.writedata[0];
    assign w_abort   = w_wr_ctrl && avs.writedata[1];
    assign w_clr     = w_wr_ctrl && avs.writedata[2];

    assign w_unused_wdata = &{1'b0, avs.writedata[31:18]};

    // Distance is taken before any subtraction so the step is clipped and never wraps.
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_step_eff = (r_step == 18'd0) ? 18'd1 : r_step;
    assign w_up       = (r_target > r_setpoint);
    assign w_dist     = w_up ? (r_target - r_setpoint) : (r_setpoint - r_target);
    assign w_inc      = (w_step_eff < w_dist) ? w_step_eff : w_dist;
    assign w_next_sp  = w_up ? (r_setpoint + w_inc) : (r_setpoint - w_inc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_setpoint   <= INIT_VALUE;
            r_target     <= INIT_VALUE;
            r_step       <= 18'd1;
            r_tick_cnt   <= 16'd0;
            r_busy       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;

            if (w_wr_tgt) begin
                r_target <= avs.writedata[17:0];
            end
            if (w_wr_step) begin
                r_step <= avs.writedata[17:0];
            end
            if (w_clr) begin
                r_done    <= 1'b0;
                r_aborted <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_wr_cur) begin
                        r_setpoint <= avs.writedata[17:0];
                    end
                    if (w_abort) begin
                        r_aborted <= 1'b1;
                    end else if (w_start) begin
                        r_done     <= 1'b0;
                        r_aborted  <= 1'b0;
                        r_tick_cnt <= 16'd0;
                        if (r_setpoint == r_target) begin
                            r_done       <= 1'b1;
                            r_done_pulse <= 1'b1;
                        end else begin
                            r_state <= ST_RAMP;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_RAMP: begin
                    // ABORT takes priority over a tick landing on the same edge.
                    if (w_abort) begin
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_aborted <= 1'b1;
                    end else if (w_tick) begin
                        r_tick_cnt <= 16'd0;
                        r_setpoint <= w_next_sp;
                        if (w_next_sp == r_target) begin
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_done_pulse <= 1'b1;
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        avs.readdata = 32'd0;
        case (avs.address)
            2'd0:    avs.readdata = {14'd0, r_setpoint};
            2'd1:    avs.readdata = {14'd0, r_target};
            2'd2:    avs.readdata = {14'd0, r_step};
            default: avs.readdata = {29'd0, r_aborted, r_done, r_busy};
        endcase
    end

    assign setpoint   = r_setpoint;
    assign busy       = r_busy;
    assign done_pulse = r_done_pulse;

endmodule

// File: tb/tb_x1_setpoint_ramp_ctrl.sv
// Randomized + directed bench for x1_setpoint_ramp_ctrl with TICK_DIV = 4.
module tb_x1_setpoint_ramp_ctrl;

    localparam int TDIV = 4;

    logic        clk;
    logic        reset_n;
    logic [17:0] setpoint;
    logic        busy;
    logic        done_pulse;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int pulse_cnt = 0;

    x1_setpoint_ramp_ctrl_if avs_if ();

    x1_setpoint_ramp_ctrl #(
        .TICK_DIV   (TDIV),
        .INIT_VALUE (18'd0)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .avs        (avs_if),
        .setpoint   (setpoint),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done_pulse) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        avs_if.address    = a;
        avs_if.writedata  = d;
        avs_if.chipselect = 1'b1;
        avs_if.write_n    = 1'b0;
        @(posedge clk);
        #1;
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        avs_if.address = a;
        #1;
        d = avs_if.readdata;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference: ramp trajectory computed from the rules with plain arithmetic.
    task automatic run_ramp(input logic [17:0] cur, input logic [17:0] tgt, input logic [17:0] stp);
        int          p0, e0, n;
        logic [17:0] p, s, d;
        logic [31:0] rd;
        bus_wr(2'd0, {14'd0, cur});
        bus_wr(2'd1, {14'd0, tgt});
        bus_wr(2'd2, {14'd0, stp});
        p0 = pulse_cnt;
        bus_wr(2'd3, 32'h1);
        e0 = cyc;
        s  = (stp == 18'd0) ? 18'd1 : stp;
        p  = cur;
        if (cur == tgt) begin
            chk("eq_pulse", {31'd0, done_pulse}, 32'd1);
            chk("eq_busy", {31'd0, busy}, 32'd0);
        end else begin
            chk("start_busy", {31'd0, busy}, 32'd1);
            n = 0;
            while (p != tgt) begin
                n++;
                wait_until(e0 + TDIV * n - 1);
                chk("hold_sp", {14'd0, setpoint}, {14'd0, p});
                wait_until(e0 + TDIV * n);
                if (tgt > p) begin
                    d = tgt - p;
                    p = p + ((s < d) ? s : d);
                end else begin
                    d = p - tgt;
                    p = p - ((s < d) ? s : d);
                end
                chk("ramp_sp", {14'd0, setpoint}, {14'd0, p});
                chk("ramp_busy", {31'd0, busy}, {31'd0, p != tgt});
                chk("ramp_pulse", {31'd0, done_pulse}, {31'd0, p == tgt});
            end
        end
        wait_until(cyc + 1);
        chk("pulse_drop", {31'd0, done_pulse}, 32'd0);
        chk("pulse_count", pulse_cnt - p0, 32'd1);
        bus_rd(2'd3, rd);
        chk("status_done", rd, 32'h2);
        bus_rd(2'd0, rd);
        chk("current_final", rd, {14'd0, tgt});
    endtask

    initial begin
        int          p0, e0;
        logic [31:0] rd;
        logic [17:0] cur, tgt, stp, eff;
        int unsigned diff;

        reset_n           = 1'b0;
        avs_if.address    = 2'd0;
        avs_if.chipselect = 1'b0;
        avs_if.write_n    = 1'b1;
        avs_if.writedata  = 32'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sp_held", {14'd0, setpoint}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        bus_rd(2'd0, rd); chk("rst_current", rd, 32'd0);
        bus_rd(2'd1, rd); chk("rst_target", rd, 32'd0);
        bus_rd(2'd2, rd); chk("rst_step", rd, 32'd1);
        bus_rd(2'd3, rd); chk("rst_status", rd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulse", {31'd0, done_pulse}, 32'd0);

        // Up-ramp 0 -> 10 step 3.
        run_ramp(18'd0, 18'd10, 18'd3);

        // Down-ramp at top of range, step 0 used as 1.
        run_ramp(18'h3FFFF, 18'h3FFF0, 18'd0);
        bus_rd(2'd2, rd); chk("step0_stored", rd, 32'd0);

        // Abort after two ticks.
        bus_wr(2'd0, 32'd0);
        bus_wr(2'd1, 32'd100);
        bus_wr(2'd2, 32'd5);
        p0 = pulse_cnt;
        bus_wr(2'd3, 32'h1);
        e0 = cyc;
        wait_until(e0 + 2 * TDIV + 1);
        chk("abort_pre_sp", {14'd0, setpoint}, 32'd10);
        bus_wr(2'd3, 32'h2);
        chk("abort_sp", {14'd0, setpoint}, 32'd10);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        bus_rd(2'd3, rd); chk("abort_status", rd, 32'h4);
        wait_until(cyc + 3 * TDIV);
        chk("abort_hold", {14'd0, setpoint}, 32'd10);
        chk("abort_no_pulse", pulse_cnt - p0, 32'd0);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3, rd); chk("clr_status", rd, 32'h0);

        // Busy protection and live retarget.
        bus_wr(2'd0, 32'd0);
        bus_wr(2'd1, 32'd40);
        bus_wr(2'd2, 32'd4);
        p0 = pulse_cnt;
        bus_wr(2'd3, 32'h1);
        e0 = cyc;
        bus_wr(2'd0, 32'd500);
        bus_wr(2'd3, 32'h1);
        wait_until(e0 + TDIV);
        chk("prot_t1", {14'd0, setpoint}, 32'd4);
        wait_until(e0 + 2 * TDIV);
        chk("prot_t2", {14'd0, setpoint}, 32'd8);
        wait_until(e0 + 3 * TDIV);
        chk("prot_t3", {14'd0, setpoint}, 32'd12);
        chk("prot_busy", {31'd0, busy}, 32'd1);
        bus_wr(2'd1, 32'd8);
        wait_until(e0 + 4 * TDIV);
        chk("retgt_sp", {14'd0, setpoint}, 32'd8);
        chk("retgt_pulse", {31'd0, done_pulse}, 32'd1);
        chk("retgt_busy", {31'd0, busy}, 32'd0);
        wait_until(cyc + 1);
        chk("retgt_pulse_cnt", pulse_cnt - p0, 32'd1);

        // START+ABORT in IDLE: only aborted is added, done kept.
        bus_wr(2'd3, 32'h3);
        bus_rd(2'd3, rd); chk("sa_idle_status", rd, 32'h6);
        chk("sa_idle_sp", {14'd0, setpoint}, 32'd8);
        bus_wr(2'd3, 32'h4);

        // START with setpoint already at target.
        run_ramp(18'd7, 18'd7, 18'd2);

        // Randomized ramps.
        for (int i = 0; i < 12; i++) begin
            cur  = 18'($urandom_range(0, 18'h3FFFF));
            stp  = 18'($urandom_range(0, 40));
            if (i == 5) stp = 18'($urandom_range(1000, 200000));
            eff  = (stp == 18'd0) ? 18'd1 : stp;
            diff = $urandom_range(0, 32'(eff) * 12);
            if ($urandom_range(0, 1) == 1)
                tgt = (32'(cur) + diff > 32'h3FFFF) ? 18'h3FFFF : 18'(32'(cur) + diff);
            else
                tgt = (32'(cur) >= diff) ? 18'(32'(cur) - diff) : 18'd0;
            run_ramp(cur, tgt, stp);
            bus_wr(2'd3, 32'h4);
        end

        // Asynchronous reset mid-ramp.
        bus_wr(2'd0, 32'd0);
        bus_wr(2'd1, 32'd1000);
        bus_wr(2'd2, 32'd3);
        bus_wr(2'd3, 32'h1);
        e0 = cyc;
        wait_until(e0 + 2 * TDIV + 1);
        chk("mid_sp", {14'd0, setpoint}, 32'd6);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_sp", {14'd0, setpoint}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        bus_rd(2'd1, rd); chk("async_rst_tgt", rd, 32'd0);
        bus_rd(2'd2, rd); chk("async_rst_step", rd, 32'd1);
        #2;
        reset_n = 1'b1;
        wait_until(cyc + 3 * TDIV);
        chk("post_rst_sp", {14'd0, setpoint}, 32'd0);
        bus_rd(2'd3, rd); chk("post_rst_status", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
